exc_flush_ctrl: RTL

//  Sequences exception/ERTN commit for the 5-stage LoongArch pipeline. Takes WB-stage trap

---
 rtl/exc_flush_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/exc_flush_ctrl.sv
// rtl/exc_flush_ctrl.sv - exception/ERTN commit sequencer: CSR strobes, fetch drain, redirect
module exc_flush_ctrl #(
  parameter int OST_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic        ertn_flush,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        inst_req_hs,
  input  logic        inst_data_ok,
  input  logic        redirect_ready,
  output logic        flush_all,
  output logic        fetch_block,
  output logic        inst_discard,
  output logic        csr_ex_we,
  output logic [5:0]  csr_ex_ecode,
  output logic [8:0]  csr_ex_esubcode,
  output logic [31:0] csr_ex_pc,
  output logic        csr_ertn_we,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_DRAIN, S_REDIR} state_t;

  localparam logic [OST_W-1:0] OST_MAX = '1;

  state_t           state;
  logic [OST_W-1:0] ost_cnt;
  logic [OST_W-1:0] ost_next;
  logic [31:0]      target;
  logic             trap_req;

  assign trap_req     = (state == S_IDLE) & (wb_ex | ertn_flush);
  assign flush_all    = trap_req | (state != S_IDLE);
  assign fetch_block  = flush_all | (ost_cnt == OST_MAX);
  assign inst_discard = inst_data_ok & (state != S_IDLE);

  // Saturating outstanding count; out-of-range steps are protocol errors and simply hold.
  always_comb begin
    ost_next = ost_cnt;
    if (inst_req_hs && !inst_data_ok && ost_cnt != OST_MAX)
      ost_next = ost_cnt + 1'b1;
    else if (!inst_req_hs && inst_data_ok && ost_cnt != '0)
      ost_next = ost_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_IDLE;
      ost_cnt         <= '0;
      target          <= '0;
      csr_ex_we       <= 1'b0;
      csr_ertn_we     <= 1'b0;
      csr_ex_ecode    <= '0;
      csr_ex_esubcode <= '0;
      csr_ex_pc       <= '0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      ost_cnt     <= ost_next;
      csr_ex_we   <= 1'b0;
      csr_ertn_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_ex || ertn_flush) begin
            csr_ex_ecode    <= wb_ecode;
            csr_ex_esubcode <= wb_esubcode;
            csr_ex_pc       <= wb_pc;
            target          <= wb_ex ? csr_eentry : csr_era;
            csr_ex_we       <= wb_ex;
            csr_ertn_we     <= ~wb_ex;
            state           <= S_COMMIT;
          end
        end
        S_COMMIT: state <= S_DRAIN;
        S_DRAIN: begin
          // Look at the next count so the redirect follows the last stale response directly.
          if (ost_next == '0) begin
            state          <= S_REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
          end
        end
        S_REDIR: begin
          if (redirect_ready) begin
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
          end
        end
      endcase
    end
  end

endmodule
